// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle multiply/divide unit for the single-cycle CPU. A MUL/MULTU/
//   DIV/DIVU instruction holds `start` high, and the unit stalls the PC until
//   the 64-bit result is ready. Multiply is radix-2 shift-add over operand
//   magnitudes. Divide is restoring division over magnitudes. The sign is
//   fixed up on the last iteration.
//
// Ports
//   clk      system clock; all state changes on the rising edge
//   rst      synchronous, active-high reset
//   start    level; high while the current instruction is a mul/div op
//   mdx      operation: 00 MUL, 01 MULTU, 10 DIV, 11 DIVU
//   a, b     rs / rt operands (multiplicand/dividend, multiplier/divisor)
//   stall    freeze PC and architectural writes: (IDLE & start) | RUN
//   done     one-cycle pulse; the result is valid and the instruction retires
//   hi, lo   product high/low word, or remainder/quotient; held between ops
//   mul_out  copy of lo; register-file writeback source for MUL
//   hwe, lwe HI/LO write strobes; equal to done except for MUL
//
// Handshake: start is a level, not a valid/ready pair. An op is accepted on
//   the rising edge where the unit is IDLE and start=1. After that edge,
//   start, mdx, a and b are ignored until done. DONE always returns to IDLE,
//   so an instruction that still holds start is never re-accepted. The next
//   instruction is accepted no earlier than the cycle after done.
//
// Optional feature (macro MULDIV_FAST_MUL_EN): MUL/MULTU produce a
//   single-cycle product and go from IDLE straight to DONE. Divide is
//   unchanged.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mdx,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mul_out,
  output logic        hwe,
  output logic        lwe
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_MUL = 2'b00;

  logic [1:0]  state;
  logic [1:0]  op;
  logic [31:0] opnd;      // multiplicand magnitude (mul) or divisor magnitude (div)
  logic [63:0] acc;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic        neg_q;     // negate product / quotient
  logic        neg_r;     // negate remainder (the dividend's sign)
  logic [5:0]  count;

  // Operand magnitudes and signs. Ops with mdx[0]=0 (MUL, DIV) are signed.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    a_neg = ~mdx[0] & a[31];
    b_neg = ~mdx[0] & b[31];
    a_mag = a_neg ? (32'd0 - a) : a;
    b_mag = b_neg ? (32'd0 - b) : b;
  end

  // One multiply step: conditionally add the multiplicand into the upper
  // half, then shift the whole accumulator right by one. The carry from the
  // add becomes the new MSB.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;

  // One restoring-divide step: shift {rem, dividend} left by one into a
  // 33-bit trial value. Subtract when the trial value is >= the divisor. The
  // new quotient bit enters at the LSB. The remainder always stays below the
  // divisor, so the low 32 bits of the subtraction are the exact difference.
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;

  logic [63:0] step;
  logic [63:0] mul_fix;
  logic [31:0] q_fix, r_fix;
  logic [31:0] fin_hi, fin_lo;

  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    mul_next  = {mul_sum, acc[31:1]};

    div_shift = {acc[63:32], acc[31]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_sub   = div_shift[31:0] - opnd;
    div_next  = {(div_ge ? div_sub : div_shift[31:0]), acc[30:0], div_ge};

    step      = op[1] ? div_next : mul_next;

    // Sign fix on the value produced by the final iteration. A zero divisor
    // needs no special case. Every trial subtract succeeds, so the quotient
    // is all ones and the remainder is |a|. The ordinary sign fix then gives
    // hi = a and lo = -1 or +1. DIV 0x80000000 / -1 also falls out naturally:
    // the magnitude quotient 0x80000000 is not negated because the signs match.
    mul_fix   = neg_q ? (64'd0 - mul_next) : mul_next;
    q_fix     = neg_q ? (32'd0 - div_next[31:0]) : div_next[31:0];
    r_fix     = neg_r ? (32'd0 - div_next[63:32]) : div_next[63:32];

    fin_hi    = op[1] ? r_fix : mul_fix[63:32];
    fin_lo    = op[1] ? q_fix : mul_fix[31:0];
  end

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extended 64x64 multiply truncated to 64 bits. This gives the signed
  // product for MUL and the unsigned product for MULTU.
  logic [63:0] fast_prod;

  always_comb begin
    fast_prod = {{32{a_neg}}, a} * {{32{b_neg}}, b};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op    <= 2'b00;
      opnd  <= 32'd0;
      acc   <= 64'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      count <= 6'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op    <= mdx;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            opnd  <= mdx[1] ? b_mag : a_mag;
            acc   <= {32'd0, (mdx[1] ? a_mag : b_mag)};
            count <= 6'd32;
            state <= S_RUN;
`ifdef MULDIV_FAST_MUL_EN
            if (!mdx[1]) begin
              hi    <= fast_prod[63:32];
              lo    <= fast_prod[31:0];
              count <= 6'd0;
              state <= S_DONE;
            end
`endif
          end
        end
        S_RUN: begin
          acc   <= step;
          count <= count - 6'd1;
          if (count == 6'd1) begin
            hi    <= fin_hi;
            lo    <= fin_lo;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall   = ((state == S_IDLE) && start) || (state == S_RUN);
    done    = (state == S_DONE);
    hwe     = done && (op != OP_MUL);
    lwe     = done && (op != OP_MUL);
    mul_out = lo;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide sequencer for the 54-instruction single-cycle CPU. It accepts the 2-bit MDX operation select and the two register operands from the controller/regfile, runs a radix-2 iterative multiply or divide, stalls the PC while busy, and delivers a 64-bit result. It also generates the HI/LO write strobes that replace the combinational Hwe/Lwe path for MULTU/DIV/DIVU. MUL's low word is returned for the register-file writeback mux.

## Interface
Parameters:
- none.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high; sampled on the rising edge of clk.
- start  in  1  level; high while the current instruction is MUL/MULTU/DIV/DIVU; held high by the stalled instruction.
- mdx  in  2  operation: 00 MUL, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  32  rs operand (multiplicand / dividend).
- b  in  32  rt operand (multiplier / divisor).
- stall  out  1  freeze PC and all architectural writes.
- done  out  1  one-cycle pulse; result valid, instruction retires this cycle.
- hi  out  32  product high word / remainder; held until next completion.
- lo  out  32  product low word / quotient; held until next completion.
- mul_out  out  32  equals lo; the RF writeback source for MUL.
- hwe  out  1  HI write strobe; equals done for MULTU/DIV/DIVU, 0 for MUL.
- lwe  out  1  LO write strobe; same rule as hwe.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - If start=1: latch mdx, a and b. For signed ops, latch |a|, |b| and the sign flags. Load iteration counter = 32. Go to RUN.
  - Else stay in IDLE.
- RUN:
  - Executes one iteration per cycle; the counter decrements.
  - On the cycle the counter reaches 0: apply the sign fix, write hi/lo, go to DONE.
  - start and mdx are ignored in RUN; operands are already latched.
- DONE:
  - done=1. Assert hwe/lwe per the rule above.
  - Next state is IDLE unconditionally, even if start is still high. The next instruction re-asserts start from IDLE.
- stall = (IDLE & start) | RUN. stall is low in DONE.
- Multiply uses shift-add over magnitudes, 64-bit accumulator.
  - MUL: signed 32x32 product. Negate the 64-bit magnitude if the operand signs differ. hi gets the upper word, lo the lower.
  - MULTU: unsigned 64-bit product.
- Divide uses restoring division over magnitudes with a 33-bit partial remainder.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - DIVU: lo = quotient, hi = remainder.
  - DIV, 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - Divide by zero, DIVU: lo = 0xFFFFFFFF, hi = a.
  - Divide by zero, DIV: lo = 0xFFFFFFFF if a ≥ 0, else 0x00000001; hi = a.
  - Divide by zero takes the normal latency and raises no exception.

## Timing
- Reset values: state IDLE, stall 0, done 0, hwe 0, lwe 0, hi 0, lo 0, mul_out 0, counter 0.
- Reset asserted in any state: the next edge gives IDLE with all outputs at reset values. A partial result is discarded and hi/lo are cleared.
- Start accepted at edge T (state IDLE):
  - stall is high in cycle T (combinational) and in cycles T+1..T+32 (RUN).
  - done/hwe/lwe pulse in cycle T+33, with stall=0.
  - Total: 33 stall cycles plus 1 retire cycle.
- hi/lo change only on the edge entering DONE. They are stable from DONE until the next DONE.
- Back-to-back instructions: the earliest next accept is the cycle after DONE (IDLE with start=1). There is no overlap.

## Configuration
- MULDIV_FAST_MUL_EN:
  - Defined: MUL/MULTU compute a single-cycle 64-bit product. IDLE with start goes directly to DONE: stall high in cycle T only, done at T+1.
  - DIV/DIVU are unchanged.
  - Undefined: all four ops take the 32-iteration path.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> at T+33 hi=0xFFFFFFFE, lo=0x00000001, hwe=lwe=1, stall high exactly 33 cycles.
- MUL a=0xFFFFFFFD (-3), b=7 -> lo=mul_out=0xFFFFFFEB, hi=0xFFFFFFFF, hwe=lwe=0, done pulse 1 cycle. With MULDIV_FAST_MUL_EN: done at T+1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100, normal latency. DIV a=-5, b=0 -> lo=0x00000001, hi=0xFFFFFFFB.
- start held high through DONE, then a new DIVU 10/3 on the following cycle -> second op accepted from IDLE, lo=3, hi=1. Changing a/b/mdx during RUN does not alter the first result.
- rst pulsed at T+10 of a DIVU -> next cycle IDLE, stall=0, hi=lo=0, no done pulse. A subsequent start completes normally.
